// File: rtl/hazard_stall_if.sv
// Hazard/stall control bundle between the pipeline datapath and hazard_stall_unit.
// master: pipeline side (drives hazard sources, consumes controls).
// slave:  hazard unit side (consumes hazard sources, drives controls and statistics).
interface hazard_stall_if #(
    parameter int unsigned REG_AW = 4
);
    localparam int unsigned STAT_W = 32;

    // Hazard sources from ID, EX and MEM
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_reg_dst;
    logic              ex_reg_wr;
    logic              ex_mem_rd;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              mem_ready;

    // Pipeline register controls
    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              ex_mem_stall;
    logic              mem_wb_bubble;

    // Statistics
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_reg_dst, ex_reg_wr, ex_mem_rd, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        input  ex_mem_stall, mem_wb_bubble,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_reg_dst, ex_reg_wr, ex_mem_rd, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        output ex_mem_stall, mem_wb_bubble,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and data-memory waits.
// Controls are decoded combinationally from the registered state and the current inputs
// so they act in the cycle the hazard is seen.
// Optional feature: define STALL_CNT_EN to get live stall_cnt / flush_cnt counters;
// otherwise both ports read 0 and no counter flops are built.
module hazard_stall_unit #(
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned LU_CYCLES    = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          ZERO_REG     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_stall_if.slave  bus
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    state_e             saved_q, saved_d;
    state_e             resume_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               rs1_hit_c;
    logic               rs2_hit_c;
    logic               dst_zero_c;
    logic               lu_hit_c;
    logic               mem_wait_c;
    logic               flush_evt_c;

    logic               pc_stall_c;
    logic               if_id_stall_c;
    logic               if_id_flush_c;
    logic               id_ex_bubble_c;
    logic               ex_mem_stall_c;
    logic               mem_wb_bubble_c;

    // Hazard detection: load-use match against EX destination, and memory wait
    always_comb begin
        rs1_hit_c  = bus.id_rs1_used & (bus.id_rs1 == bus.ex_reg_dst);
        rs2_hit_c  = bus.id_rs2_used & (bus.id_rs2 == bus.ex_reg_dst);
        dst_zero_c = (bus.ex_reg_dst == REG_AW'(0));
        lu_hit_c   = bus.ex_mem_rd & bus.ex_reg_wr & (rs1_hit_c | rs2_hit_c)
                     & ~(ZERO_REG & dst_zero_c);
        mem_wait_c = bus.mem_req & ~bus.mem_ready;
    end

    // Next state and control decode; wait > taken branch > load-use
    always_comb begin
        state_d         = state_q;
        saved_d         = saved_q;
        cnt_d           = cnt_q;
        flush_evt_c     = 1'b0;
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        ex_mem_stall_c  = 1'b0;
        mem_wb_bubble_c = 1'b0;

        // A frozen sequence picks up where it left off once the wait clears
        resume_c = (state_q == MEM_WAIT) ? saved_q : state_q;

        if (mem_wait_c) begin
            pc_stall_c      = 1'b1;
            if_id_stall_c   = 1'b1;
            ex_mem_stall_c  = 1'b1;
            mem_wb_bubble_c = 1'b1;
            state_d         = MEM_WAIT;
            saved_d         = resume_c;
        end else begin
            state_d = resume_c;
            case (resume_c)
                RUN: begin
                    if (bus.ex_branch_taken) begin
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        flush_evt_c    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end else if (lu_hit_c) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        if (LU_CYCLES > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = CNT_W'(LU_CYCLES - 1);
                        end
                    end
                end
                FLUSH: begin
                    // ID holds a wrong-path instruction, so its operands are ignored
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    cnt_d          = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                LU_STALL: begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    cnt_d          = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Reset forces every control low even while hazard inputs are active
        if (!rst_n) begin
            flush_evt_c     = 1'b0;
            pc_stall_c      = 1'b0;
            if_id_stall_c   = 1'b0;
            if_id_flush_c   = 1'b0;
            id_ex_bubble_c  = 1'b0;
            ex_mem_stall_c  = 1'b0;
            mem_wb_bubble_c = 1'b0;
        end
    end

    // State, resume-state and sequence counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_stall      = pc_stall_c;
    assign bus.if_id_stall   = if_id_stall_c;
    assign bus.if_id_flush   = if_id_flush_c;
    assign bus.id_ex_bubble  = id_ex_bubble_c;
    assign bus.ex_mem_stall  = ex_mem_stall_c;
    assign bus.mem_wb_bubble = mem_wb_bubble_c;

`ifdef STALL_CNT_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters: stall = any pc_stall cycle, flush = taken branch in RUN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall_c && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
        if (flush_evt_c && (flush_cnt_q != {STAT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + STAT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    logic unused_flush_evt;

    assign bus.stall_cnt    = '0;
    assign bus.flush_cnt    = '0;
    assign unused_flush_evt = flush_evt_c;
`endif

endmodule
